// File: rtl/booth_product_accumulator.sv
// Saturating block accumulator for signed Booth-multiplier products.
// Sums len+1 products per block and presents the sum on a valid/ready output.
module booth_product_accumulator #(
  parameter int PW = 8,
  parameter int AW = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic [PW-1:0] product,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] acc_out,
  output logic          overflow,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  state_t        state, state_nxt;
  logic [AW-1:0] acc;
  logic          ovf;
  logic [CW-1:0] remaining;
  logic          beat;
  logic [AW:0]   sum;
  logic [AW-1:0] sum_sat;
  logic          sum_ovf;

  assign beat = (state == ACCUM) && in_valid;

  // One guard bit is enough: |acc + product| < 2^AW since AW >= PW + 1.
  always_comb begin
    sum     = {acc[AW-1], acc} + {{(AW+1-PW){product[PW-1]}}, product};
    sum_ovf = sum[AW] ^ sum[AW-1];
    sum_sat = sum[AW-1:0];
    if (sum_ovf) sum_sat = sum[AW] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (beat && remaining == '0) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  // The block counter counts down, so len = 2^CW-1 needs no extra bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else if (state == IDLE && start) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= len;
    end else if (beat) begin
      acc <= sum_sat;
      ovf <= ovf | sum_ovf;
      if (remaining != '0) remaining <= remaining - 1'b1;
    end
  end

  assign acc_out  = acc;
  assign overflow = ovf;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench: a 16-bit and a 10-bit accumulator share one stimulus stream
// so each block checks both the wide (exact) and the narrow (saturating) sum.
module tb_booth_product_accumulator;

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid, out_ready;
  logic [3:0]        len;
  logic [7:0]        product;
  logic              in_ready16, ovf16, ov16, busy16;
  logic              in_ready10, ovf10, ov10, busy10;
  logic signed [15:0] acc16;
  logic signed [9:0]  acc10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_product_accumulator #(.PW(8), .AW(16), .CW(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .product(product),
    .in_valid(in_valid), .in_ready(in_ready16), .acc_out(acc16),
    .overflow(ovf16), .out_valid(ov16), .out_ready(out_ready), .busy(busy16));

  booth_product_accumulator #(.PW(8), .AW(10), .CW(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .product(product),
    .in_valid(in_valid), .in_ready(in_ready10), .acc_out(acc10),
    .overflow(ovf10), .out_valid(ov10), .out_ready(out_ready), .busy(busy10));

  typedef struct {
    int               n;
    int               blen;
    logic [15:0][7:0] prod;
    logic [15:0]      vld;
    int               e16;
    bit               o16;
    int               e10;
    bit               o10;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int n, int blen, int e16, bit o16, int e10, bit o10);
    vec_t v;
    v.n = n; v.blen = blen; v.prod = '0; v.vld = '1;
    v.e16 = e16; v.o16 = o16; v.e10 = e10; v.o10 = o10;
    return v;
  endfunction

  // Entered and left one delta after a clock edge, inputs idle.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    start = 1'b1;
    len = 4'(v.blen);
    step(); cyc++;
    start = 1'b0;
    chk({tag, " busy"}, int'(busy16 & busy10), 1);
    for (int i = 0; i < v.n; i++) begin
      in_valid = v.vld[i];
      product  = v.prod[i];
      chk({tag, " in_ready"}, int'(in_ready16 & in_ready10), 1);
      step(); cyc++;
    end
    in_valid = 1'b0;
    chk({tag, " out_valid"}, int'({ov16, ov10}), 3);
    chk({tag, " acc16"}, int'(acc16), v.e16);
    chk({tag, " ovf16"}, int'(ovf16), int'(v.o16));
    chk({tag, " acc10"}, int'(acc10), v.e10);
    chk({tag, " ovf10"}, int'(ovf10), int'(v.o10));
    step(); cyc++;
    chk({tag, " out_valid drop"}, int'({ov16, ov10}), 0);
    chk({tag, " idle"}, int'({busy16, busy10}), 0);
    chk({tag, " cycles"}, cyc, v.n + 2);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = '0; product = '0;

    vecs[0] = mk(4, 3, 8, 0, 8, 0);
    vecs[0].prod[0] = 8'd5;     vecs[0].prod[1] = 8'(-3);
    vecs[0].prod[2] = 8'd7;     vecs[0].prod[3] = 8'(-1);
    vecs[1] = mk(5, 4, 635, 0, 511, 1);
    for (int i = 0; i < 5; i++) vecs[1].prod[i] = 8'd127;
    vecs[2] = mk(6, 5, -540, 0, -412, 1);
    for (int i = 0; i < 5; i++) vecs[2].prod[i] = 8'(-128);
    vecs[2].prod[5] = 8'd100;
    vecs[3] = mk(6, 2, 60, 0, 60, 0);
    vecs[3].prod[0] = 8'd10; vecs[3].prod[1] = 8'd99; vecs[3].prod[2] = 8'd99;
    vecs[3].prod[3] = 8'd20; vecs[3].prod[4] = 8'd99; vecs[3].prod[5] = 8'd30;
    vecs[3].vld[5:0] = 6'b101001;
    vecs[4] = mk(1, 0, -7, 0, -7, 0);
    vecs[4].prod[0] = 8'(-7);
    vecs[5] = mk(16, 15, 2032, 0, 511, 1);
    for (int i = 0; i < 16; i++) vecs[5].prod[i] = 8'd127;

    #2;
    chk("reset acc16", int'(acc16), 0);
    chk("reset acc10", int'(acc10), 0);
    chk("reset flags", int'({ovf16, ov16, in_ready16, busy16, ovf10, ov10, in_ready10, busy10}), 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Products offered while idle must not be taken.
    in_valid = 1'b1; product = 8'd55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle in_ready", int'({in_ready16, in_ready10}), 0);
    end
    in_valid = 1'b0;
    chk("idle acc16", int'(acc16), 2032);
    chk("idle acc10", int'(acc10), 511);

    // Backpressure: output frozen, start and in_valid ignored while held.
    out_ready = 1'b0;
    start = 1'b1; len = 4'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; product = 8'd3; step();
    product = 8'd4; step();
    for (int i = 0; i < 10; i++) begin
      start = i[0]; in_valid = ~i[0]; len = 4'd9; product = 8'd50;
      step();
      chk("bp out_valid", int'({ov16, ov10}), 3);
      chk("bp acc16", int'(acc16), 7);
      chk("bp state", int'({ovf16, in_ready16, in_ready10, busy16}), 1);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp release", int'({ov16, busy16, busy10}), 0);
    step();
    chk("bp no restart", int'({busy16, busy10}), 0);
    chk("bp acc kept", int'(acc10), 7);

    // Reset in the middle of a block.
    start = 1'b1; len = 4'd3;
    step();
    start = 1'b0;
    in_valid = 1'b1; product = 8'd10; step();
    product = 8'd20; step();
    in_valid = 1'b0;
    chk("mid acc16", int'(acc16), 30);
    rst_n = 1'b0;
    #1;
    chk("async rst acc", int'(acc16) | int'(acc10), 0);
    chk("async rst flags", int'({ovf16, ov16, in_ready16, busy16, ovf10, ov10, in_ready10, busy10}), 0);
    #20;
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("post rst idle", int'({busy16, busy10}), 0);
    run_vec(vecs[4], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
